// File: rtl/unloader_word_read_adapter_if.sv
// Word-wide memory read port shared with other memory clients.
// The adapter drives the request side; the memory arbiter answers with a
// one-cycle mem_ack pulse that carries mem_data in the same cycle.
interface unloader_word_read_adapter_if #(
    parameter int ADDRESS_SIZE = 28
);
    logic                    mem_rd;
    logic [ADDRESS_SIZE-2:0] mem_addr;
    logic                    mem_ack;
    logic [15:0]             mem_data;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/unloader_word_read_adapter.sv
// Byte-to-word read adapter for the save/data unloader memory port.
// Rising edges of read_en are byte requests. A one-word cache serves
// sequential bytes without touching memory. Misses become a held
// mem_rd request on the shared word port. A sticky late_error flags any
// response that lands after the unloader has already sampled read_data.
module unloader_word_read_adapter #(
    parameter int ADDRESS_SIZE     = 28,
    parameter int RESPONSE_LATENCY = 1,
    parameter bit LOW_BYTE_FIRST   = 1'b1
) (
    input  logic                          clk_memory,
    input  logic                          reset_n,
    input  logic                          read_en,
    input  logic [ADDRESS_SIZE-1:0]       read_addr,
    output logic [7:0]                    read_data,
    unloader_word_read_adapter_if.master  mem,
    input  logic                          invalidate,
    output logic                          late_error
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam logic [5:0] DEADLINE_MAX = 6'd63;

    state_t                  state_q,      state_d;
    logic                    prev_en_q,    prev_en_d;
    logic [7:0]              read_data_q,  read_data_d;
    logic                    mem_rd_q,     mem_rd_d;
    logic [ADDRESS_SIZE-2:0] mem_addr_q,   mem_addr_d;
    logic                    cap_lsb_q,    cap_lsb_d;
    logic [5:0]              deadline_q,   deadline_d;
    logic                    late_error_q, late_error_d;
    logic                    valid_q,      valid_d;
    logic [ADDRESS_SIZE-2:0] tag_q,        tag_d;
    logic [15:0]             word_q,       word_d;
    logic                    inv_seen_q,   inv_seen_d;

    logic                    req;
    logic                    hit;
    logic [ADDRESS_SIZE-2:0] word_addr;

    // Pick the requested byte out of a 16-bit word; odd addresses take the
    // high byte when the low byte comes first, and the reverse otherwise.
    function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic odd);
        if (odd ^ ~LOW_BYTE_FIRST)
            return w[15:8];
        else
            return w[7:0];
    endfunction

    assign word_addr = read_addr[ADDRESS_SIZE-1:1];
    assign req       = read_en & ~prev_en_q;
    // invalidate in the request cycle forces a miss so a just-written word is refetched
    assign hit       = valid_q & (tag_q == word_addr) & ~invalidate;

    // Next-state logic for the request detector, cache, fetch FSM and deadline tracking
    always_comb begin
        state_d      = state_q;
        prev_en_d    = read_en;
        read_data_d  = read_data_q;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        cap_lsb_d    = cap_lsb_q;
        deadline_d   = deadline_q;
        late_error_d = late_error_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        word_d       = word_q;
        inv_seen_d   = inv_seen_q;

        if (invalidate)
            valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                inv_seen_d = 1'b0;
                if (req) begin
                    if (hit) begin
                        read_data_d = sel_byte(word_q, read_addr[0]);
                    end else begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = word_addr;
                        cap_lsb_d  = read_addr[0];
                        deadline_d = 6'd1;
                        state_d    = FETCH;
                    end
                end
            end

            FETCH: begin
                if (invalidate)
                    inv_seen_d = 1'b1;
                // The adapter holds only one outstanding fetch; a new byte
                // request now cannot be answered in time.
                if (req)
                    late_error_d = 1'b1;
                if (mem.mem_ack) begin
                    mem_rd_d    = 1'b0;
                    word_d      = mem.mem_data;
                    tag_d       = mem_addr_q;
                    // A write seen during the fetch may have made this data stale
                    valid_d     = ~inv_seen_q & ~invalidate;
                    read_data_d = sel_byte(mem.mem_data, cap_lsb_q);
                    if (int'(deadline_q) > RESPONSE_LATENCY - 1)
                        late_error_d = 1'b1;
                    inv_seen_d  = 1'b0;
                    state_d     = IDLE;
                end else if (deadline_q != DEADLINE_MAX) begin
                    deadline_d = deadline_q + 6'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Register all state; active-low synchronous reset drops mem_rd on the same edge
    always_ff @(posedge clk_memory) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            prev_en_q    <= 1'b0;
            read_data_q  <= 8'h00;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            cap_lsb_q    <= 1'b0;
            deadline_q   <= 6'd0;
            late_error_q <= 1'b0;
            valid_q      <= 1'b0;
            tag_q        <= '0;
            word_q       <= 16'h0000;
            inv_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_en_q    <= prev_en_d;
            read_data_q  <= read_data_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            cap_lsb_q    <= cap_lsb_d;
            deadline_q   <= deadline_d;
            late_error_q <= late_error_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            word_q       <= word_d;
            inv_seen_q   <= inv_seen_d;
        end
    end

    assign read_data    = read_data_q;
    assign mem.mem_rd   = mem_rd_q;
    assign mem.mem_addr = mem_addr_q;
    assign late_error   = late_error_q;

endmodule

// File: tb/tb_unloader_word_read_adapter.sv
// Scoreboard bench for unloader_word_read_adapter.
// Two instances share every input: A (RESPONSE_LATENCY=3, low byte first)
// and B (RESPONSE_LATENCY=2, high byte first). Stimulus tasks push the
// expected outcome of each request edge / memory acknowledge into a queue;
// a monitor pops and compares whenever one of those events occurs.
module tb_unloader_word_read_adapter;

    localparam int AS = 28;

    localparam int K_HIT  = 0;
    localparam int K_MISS = 1;
    localparam int K_ACK  = 2;
    localparam int K_DROP = 3;

    typedef struct {
        int          kind;
        logic [26:0] waddr;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        la;
        logic        lb;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          read_en = 1'b0;
    logic [AS-1:0] read_addr = '0;
    logic          invalidate = 1'b0;
    logic          mem_ack = 1'b0;
    logic [15:0]   mem_data = 16'h0;
    logic [7:0]    read_data_a, read_data_b;
    logic          late_a, late_b;

    int   n_cmp = 0;
    int   n_err = 0;
    int   rd_count = 0;
    exp_t sb[$];
    logic exp_late_a = 1'b0;
    logic exp_late_b = 1'b0;
    logic tb_prev_en = 1'b0;

    unloader_word_read_adapter_if #(.ADDRESS_SIZE(AS)) mem_if_a ();
    unloader_word_read_adapter_if #(.ADDRESS_SIZE(AS)) mem_if_b ();

    assign mem_if_a.mem_ack  = mem_ack;
    assign mem_if_a.mem_data = mem_data;
    assign mem_if_b.mem_ack  = mem_ack;
    assign mem_if_b.mem_data = mem_data;

    unloader_word_read_adapter #(
        .ADDRESS_SIZE(AS), .RESPONSE_LATENCY(3), .LOW_BYTE_FIRST(1'b1)
    ) dut_a (
        .clk_memory(clk), .reset_n(reset_n), .read_en(read_en),
        .read_addr(read_addr), .read_data(read_data_a), .mem(mem_if_a),
        .invalidate(invalidate), .late_error(late_a)
    );

    unloader_word_read_adapter #(
        .ADDRESS_SIZE(AS), .RESPONSE_LATENCY(2), .LOW_BYTE_FIRST(1'b0)
    ) dut_b (
        .clk_memory(clk), .reset_n(reset_n), .read_en(read_en),
        .read_addr(read_addr), .read_data(read_data_b), .mem(mem_if_b),
        .invalidate(invalidate), .late_error(late_b)
    );

    always #5 clk = ~clk;

    always @(posedge mem_if_a.mem_rd) rd_count = rd_count + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int kind, input logic [26:0] waddr,
                            input logic [7:0] ea, input logic [7:0] eb);
        exp_t e;
        e.kind = kind; e.waddr = waddr; e.ea = ea; e.eb = eb;
        e.la = exp_late_a; e.lb = exp_late_b;
        sb.push_back(e);
    endtask

    // Monitor: detect request edges and accepted acknowledges, then check
    // the registered outputs just after the edge.
    initial begin
        bit   ev_req, ev_ack;
        exp_t e;
        forever begin
            @(posedge clk);
            ev_req = reset_n && read_en && !tb_prev_en;
            ev_ack = reset_n && mem_ack && mem_if_a.mem_rd;
            tb_prev_en = reset_n ? read_en : 1'b0;
            #1;
            for (int n = 0; n < int'(ev_req) + int'(ev_ack); n++) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    case (e.kind)
                        K_HIT: begin
                            chk("hit_data_a", {24'd0, read_data_a}, {24'd0, e.ea});
                            chk("hit_data_b", {24'd0, read_data_b}, {24'd0, e.eb});
                            chk("hit_no_rd_a", {31'd0, mem_if_a.mem_rd}, 32'd0);
                            chk("hit_no_rd_b", {31'd0, mem_if_b.mem_rd}, 32'd0);
                        end
                        K_MISS: begin
                            chk("miss_rd_a", {31'd0, mem_if_a.mem_rd}, 32'd1);
                            chk("miss_rd_b", {31'd0, mem_if_b.mem_rd}, 32'd1);
                            chk("miss_addr_a", {5'd0, mem_if_a.mem_addr}, {5'd0, e.waddr});
                            chk("miss_addr_b", {5'd0, mem_if_b.mem_addr}, {5'd0, e.waddr});
                        end
                        K_ACK: begin
                            chk("ack_data_a", {24'd0, read_data_a}, {24'd0, e.ea});
                            chk("ack_data_b", {24'd0, read_data_b}, {24'd0, e.eb});
                            chk("ack_rd_low_a", {31'd0, mem_if_a.mem_rd}, 32'd0);
                            chk("ack_rd_low_b", {31'd0, mem_if_b.mem_rd}, 32'd0);
                        end
                        default: begin
                            chk("drop_rd_a", {31'd0, mem_if_a.mem_rd}, 32'd1);
                            chk("drop_addr_a", {5'd0, mem_if_a.mem_addr}, {5'd0, e.waddr});
                        end
                    endcase
                    chk("late_a", {31'd0, late_a}, {31'd0, e.la});
                    chk("late_b", {31'd0, late_b}, {31'd0, e.lb});
                    $display("txn kind=%0d waddr=0x%0h rd_a=0x%02h rd_b=0x%02h late=%0b%0b",
                             e.kind, e.waddr, read_data_a, read_data_b, late_a, late_b);
                end
            end
        end
    end

    // Request that should hit the cache: data one edge after the request edge.
    task automatic hit_read(input logic [AS-1:0] addr, input logic [7:0] ea, input logic [7:0] eb);
        push_exp(K_HIT, addr[AS-1:1], ea, eb);
        @(negedge clk); read_en = 1'b1; read_addr = addr;
        @(negedge clk);
        @(negedge clk); read_en = 1'b0;
        @(negedge clk);
    endtask

    // Request that should miss; mem_ack arrives in cycle k of mem_rd, so the
    // deadline counter reads k when the acknowledge is sampled.
    task automatic miss_read(input logic [AS-1:0] addr, input logic [15:0] word, input int k,
                             input logic [7:0] ea, input logic [7:0] eb,
                             input bit inv_with_req, input bit inv_in_fetch, input bit drop);
        push_exp(K_MISS, addr[AS-1:1], 8'h00, 8'h00);
        @(negedge clk); read_en = 1'b1; read_addr = addr; invalidate = inv_with_req;
        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            invalidate = (c == 1) && inv_in_fetch;
            if (drop && c == 1) read_en = 1'b0;
            if (drop && c == 2) begin
                read_en = 1'b1;
                exp_late_a = 1'b1;
                exp_late_b = 1'b1;
                push_exp(K_DROP, addr[AS-1:1], 8'h00, 8'h00);
            end
        end
        if (k > 2) exp_late_a = 1'b1;
        if (k > 1) exp_late_b = 1'b1;
        push_exp(K_ACK, addr[AS-1:1], ea, eb);
        mem_ack = 1'b1; mem_data = word;
        @(negedge clk); mem_ack = 1'b0; mem_data = 16'h0; read_en = 1'b0; invalidate = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int rd_before;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_read_data_a", {24'd0, read_data_a}, 32'd0);
        chk("rst_read_data_b", {24'd0, read_data_b}, 32'd0);
        chk("rst_mem_rd_a", {31'd0, mem_if_a.mem_rd}, 32'd0);
        chk("rst_mem_addr_a", {5'd0, mem_if_a.mem_addr}, 32'd0);
        chk("rst_late_a", {31'd0, late_a}, 32'd0);
        chk("rst_late_b", {31'd0, late_b}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: cold miss at 0x100, fast memory
        miss_read(28'h0000100, 16'hBEEF, 1, 8'hEF, 8'hBE, 1'b0, 1'b0, 1'b0);
        // 2: odd byte of the same word hits
        hit_read(28'h0000101, 8'hBE, 8'hEF);

        // 3: four-byte burst, two word fetches
        rd_before = rd_count;
        miss_read(28'h0000200, 16'h2211, 1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
        hit_read(28'h0000201, 8'h22, 8'h11);
        miss_read(28'h0000202, 16'h4433, 1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        hit_read(28'h0000203, 8'h44, 8'h33);
        chk("burst_fetch_count", rd_count - rd_before, 32'd2);

        // 4: slow memory sets the sticky flag; later good reads keep it set
        miss_read(28'h0000400, 16'h5A6B, 4, 8'h6B, 8'h5A, 1'b0, 1'b0, 1'b0);
        hit_read(28'h0000401, 8'h5A, 8'h6B);
        miss_read(28'h0000402, 16'h7788, 1, 8'h88, 8'h77, 1'b0, 1'b0, 1'b0);

        // 5: invalidate coincident with a would-be hit, then during the refetch
        miss_read(28'h0000100, 16'hBEEF, 1, 8'hEF, 8'hBE, 1'b0, 1'b0, 1'b0);
        miss_read(28'h0000101, 16'hCAFE, 2, 8'hCA, 8'hFE, 1'b1, 1'b1, 1'b0);
        miss_read(28'h0000100, 16'h1234, 1, 8'h34, 8'h12, 1'b0, 1'b0, 1'b0);

        // 6: reset while a fetch is outstanding
        push_exp(K_MISS, 27'h0000280, 8'h00, 8'h00);
        @(negedge clk); read_en = 1'b1; read_addr = 28'h0000500;
        @(negedge clk); reset_n = 1'b0; read_en = 1'b0;
        exp_late_a = 1'b0; exp_late_b = 1'b0;
        @(negedge clk);
        chk("midfetch_rst_rd_a", {31'd0, mem_if_a.mem_rd}, 32'd0);
        chk("midfetch_rst_rd_b", {31'd0, mem_if_b.mem_rd}, 32'd0);
        chk("midfetch_rst_late_a", {31'd0, late_a}, 32'd0);
        chk("midfetch_rst_late_b", {31'd0, late_b}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk); mem_ack = 1'b1; mem_data = 16'h5555;
        @(negedge clk); mem_ack = 1'b0; mem_data = 16'h0;
        chk("stray_ack_rd_a", {31'd0, mem_if_a.mem_rd}, 32'd0);
        chk("stray_ack_data_a", {24'd0, read_data_a}, 32'd0);
        chk("stray_ack_data_b", {24'd0, read_data_b}, 32'd0);
        miss_read(28'h0000100, 16'h9ABC, 1, 8'hBC, 8'h9A, 1'b0, 1'b0, 1'b0);

        // 7: a second request edge during a fetch is dropped and flagged
        miss_read(28'h0000600, 16'hD00D, 4, 8'h0D, 8'hD0, 1'b0, 1'b0, 1'b1);
        // top-of-range byte address maps to the top word address
        miss_read(28'hFFFFFFF, 16'hA1B2, 1, 8'hA1, 8'hB2, 1'b0, 1'b0, 1'b0);

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        if (sb.size() != 0)
            chk("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/unloader_word_read_adapter.md
Name: unloader_word_read_adapter

Overview:
- Sits on the memory-clock side directly downstream of the APF save/data unloader's memory port.
- Converts the unloader's byte read requests (read_en / read_addr / read_data) into 16-bit word reads on a shared variable-latency memory port with a req/ack handshake.
- Keeps a single-word cache so sequential byte reads hit in one cycle.
- Flags any response that misses the unloader's fixed sampling deadline.

Parameters:
- ADDRESS_SIZE, 28, byte address width of read_addr.
- RESPONSE_LATENCY, 1, cycles after the request edge by which read_data must be valid; the unloader's READ_MEM_CLOCK_DELAY is set equal to this.
- LOW_BYTE_FIRST, 1, 1: even byte address maps to mem_data[7:0]; 0: even byte address maps to mem_data[15:8].

Ports:
- clk_memory  in  1  memory-domain clock; only clock in the block.
- reset_n  in  1  synchronous, active-low reset.
- read_en  in  1  from unloader; held high for RESPONSE_LATENCY cycles per byte; only the rising edge is a request.
- read_addr  in  ADDRESS_SIZE  byte address; stable while read_en is high.
- read_data  out  8  byte returned to unloader.
- mem_rd  out  1  word read request; held until mem_ack.
- mem_addr  out  ADDRESS_SIZE-1  word address (read_addr[ADDRESS_SIZE-1:1]).
- mem_ack  in  1  one-cycle pulse; mem_data valid in the same cycle.
- mem_data  in  16  word read data.
- invalidate  in  1  clears the cache; asserted by the core when it writes the memory.
- late_error  out  1  sticky deadline-miss / overrun flag.

Behaviour:
Reset (reset_n=0 at a clk_memory edge):
- read_data=0, mem_rd=0, mem_addr=0, late_error=0.
- Cache valid=0, tag=0, word=0; state=IDLE; deadline counter=0.
- Reset mid-FETCH drops mem_rd in the same edge. A mem_ack arriving after reset is ignored.

Request detection:
- prev_en is registered. A request is read_en & ~prev_en.
- read_addr is captured on the request edge.

States:
- IDLE
  - Request with hit (valid & tag==read_addr[ADDRESS_SIZE-1:1] & ~invalidate):
    - read_data <= selected byte of the cached word at the next edge (latency 1).
    - Stay in IDLE.
  - Request with miss:
    - mem_rd <= 1 and mem_addr <= word address at the next edge.
    - Deadline counter <= 1. Go to FETCH.
- FETCH
  - mem_rd stays high and mem_addr stays stable until mem_ack.
  - Deadline counter increments each cycle, saturating at 63.
  - On mem_ack:
    - mem_rd <= 0; word <= mem_data; tag <= captured word address.
    - valid <= ~invalidate_seen.
    - read_data <= byte selected by the captured addr[0].
    - Go to IDLE.
  - A request edge while in FETCH is dropped and sets late_error.

Byte select:
- LOW_BYTE_FIRST=1: addr[0]=0 selects [7:0]; addr[0]=1 selects [15:8].
- LOW_BYTE_FIRST=0: the mapping is reversed.

Deadline:
- If the counter exceeds RESPONSE_LATENCY-1 when mem_ack arrives, late_error <= 1. This means read_data updated after the unloader sampled it.
- A hit always meets RESPONSE_LATENCY>=1.
- late_error clears only on reset.

Invalidate:
- Clears valid at the next edge.
- When invalidate coincides with a request edge, invalidate wins and the request is a miss.
- invalidate during FETCH sets invalidate_seen. The fill still returns data to the unloader but leaves valid=0. invalidate_seen clears on entry to IDLE.

Other boundary conditions:
- mem_ack while in IDLE is ignored.
- read_data holds its value between requests.
- Address 2^ADDRESS_SIZE-1 requests word address 2^(ADDRESS_SIZE-1)-1. There is no wrap or carry logic.

Test Plan:
1. Reset then miss: read_addr=0x0000100 rising, mem_ack 1 cycle after mem_rd with mem_data=0xBEEF, RESPONSE_LATENCY=3 -> mem_addr=0x0000080, mem_rd high 1 cycle, read_data=0xEF, late_error=0.
2. Hit following fill: request 0x0000101 -> no mem_rd, read_data=0xBE exactly one edge after the request edge; with LOW_BYTE_FIRST=0, the same sequence gives 0xBE then 0xEF.
3. Full 4-byte unloader burst 0x200..0x203, memory words 0x2211/0x4433 -> exactly 2 mem_rd transactions; read_data sequence 0x11,0x22,0x33,0x44.
4. Late memory: RESPONSE_LATENCY=2, mem_ack 4 cycles after mem_rd -> read_data=correct byte but late_error=1, and it stays 1 through further good reads until reset_n=0.
5. Invalidate: fill word 0x0080, pulse invalidate coincident with a request to 0x0000101 -> miss, mem_rd reissued; invalidate during that FETCH -> data returned, next request to 0x0000100 misses again.
6. Reset mid-FETCH: reset_n=0 while mem_rd=1 -> mem_rd=0 next edge, subsequent stray mem_ack ignored, valid=0, first post-reset request misses.
